// File: rtl/decoder_pkg.sv
// Shared widths and one-hot codes for the 2-to-4 decoder family.
package decoder_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 1 << SEL_W;

  localparam logic [OUT_W-1:0] ONEHOT_0 = 4'b0001;
  localparam logic [OUT_W-1:0] ONEHOT_1 = 4'b0010;
  localparam logic [OUT_W-1:0] ONEHOT_2 = 4'b0100;
  localparam logic [OUT_W-1:0] ONEHOT_3 = 4'b1000;

  // Zero when disabled, otherwise the single bit selected by sel.
  function automatic logic [OUT_W-1:0] onehot_of(input logic [SEL_W-1:0] sel,
                                                 input logic             en);
    logic [OUT_W-1:0] r;
    r = '0;
    if (en) begin
      r[sel] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_2x4_comb.sv
// Pure combinational 2-to-4 decode: y[k] = e & (i == k).
module decoder_2x4_comb
  import decoder_pkg::*;
(
  input  logic [SEL_W-1:0] i,
  input  logic             e,
  output logic [OUT_W-1:0] y
);

  // One AND term per output line; no two terms can be true together.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
    assign y[gi] = e & (i == SEL_W'(gi));
  end

endmodule

// File: rtl/decoder_2x4_sync.sv
// Registered (or optionally combinational) 2-to-4 decoder with enable and
// synchronous active-low reset. The registered build gives downstream logic
// glitch-free one-hot selects with one cycle of latency.
module decoder_2x4_sync
  import decoder_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] I,
  input  logic             E,
  output logic [OUT_W-1:0] Y
);

  logic [OUT_W-1:0] dec;

  decoder_2x4_comb u_comb (
    .i (I),
    .e (E),
    .y (dec)
  );

  if (OUT_REG) begin : g_reg
    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;

    // Next output is simply the current decode; reset is applied in the flop.
    always_comb begin
      y_d = dec;
    end

    // Output register: reset wins over everything, otherwise load the decode.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        y_q <= '0;
      end else begin
        y_q <= y_d;
      end
    end

    assign Y = y_q;

    // A disabled sample must show up as an all-zero output one edge later.
    a_disable_clears : assert property (@(posedge clk) disable iff (!rst_n)
                                        !E |=> (Y == '0));
  end else begin : g_comb
    // Combinational build: reset still forces the output low immediately.
    always_comb begin
      Y = rst_n ? dec : '0;
    end
  end

  // The output is never anything but zero or a single set bit.
  a_onehot0 : assert property (@(posedge clk) $onehot0(Y));

endmodule

// File: tb/tb_decoder_2x4_sync.sv
// Directed bench for decoder_2x4_sync: registered build plus a combinational build.
module tb_decoder_2x4_sync;

  logic       clk;
  logic       rst_n;
  logic [1:0] I;
  logic       E;
  logic [3:0] Y;

  logic       rst_n_c;
  logic [1:0] I_c;
  logic       E_c;
  logic [3:0] Y_c;

  int n_cmp = 0;
  int n_mis = 0;

  decoder_2x4_sync #(.OUT_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .I     (I),
    .E     (E),
    .Y     (Y)
  );

  decoder_2x4_sync #(.OUT_REG(1'b0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n_c),
    .I     (I_c),
    .E     (E_c),
    .Y     (Y_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_y(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: Y=%b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: Y=%b", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_en [4];

  initial begin
    exp_en[0] = 4'b0001;
    exp_en[1] = 4'b0010;
    exp_en[2] = 4'b0100;
    exp_en[3] = 4'b1000;

    rst_n   = 1'b0;
    E       = 1'b1;
    I       = 2'b11;
    rst_n_c = 1'b1;
    E_c     = 1'b0;
    I_c     = 2'b00;

    // Reset held two edges with an active select on the inputs.
    step();
    check_y("reset_c1", Y, 4'b0000);
    step();
    check_y("reset_c2", Y, 4'b0000);
    rst_n = 1'b1;
    step();
    check_y("release", Y, 4'b1000);

    // Disabled sweep.
    E = 1'b0;
    for (int k = 0; k < 4; k++) begin
      I = 2'(k);
      step();
      check_y($sformatf("dis_i%0d", k), Y, 4'b0000);
    end

    // Enabled sweep.
    E = 1'b1;
    for (int k = 0; k < 4; k++) begin
      I = 2'(k);
      step();
      check_y($sformatf("en_i%0d", k), Y, exp_en[k]);
    end

    // Input change between edges must not reach the output early.
    I = 2'b00;
    #3;
    check_y("mid_cycle_hold", Y, 4'b1000);
    step();
    check_y("mid_cycle_load", Y, 4'b0001);

    // Enable toggle with select held.
    I = 2'b10;
    step();
    check_y("tog_on", Y, 4'b0100);
    E = 1'b0;
    step();
    check_y("tog_off", Y, 4'b0000);
    E = 1'b1;
    step();
    check_y("tog_on2", Y, 4'b0100);

    // Mid-operation reset pulse.
    I = 2'b01;
    step();
    check_y("run_i1", Y, 4'b0010);
    rst_n = 1'b0;
    step();
    check_y("mid_reset", Y, 4'b0000);
    rst_n = 1'b1;
    step();
    check_y("mid_release", Y, 4'b0010);

    // Simultaneous change of E and I.
    E = 1'b0;
    I = 2'b00;
    step();
    check_y("simul_off", Y, 4'b0000);
    E = 1'b1;
    I = 2'b11;
    step();
    check_y("simul_on", Y, 4'b1000);

    // Combinational build: check between edges, no clock needed.
    @(negedge clk);
    E_c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      I_c = 2'(k);
      #1;
      check_y($sformatf("comb_i%0d", k), Y_c, exp_en[k]);
    end
    E_c = 1'b0;
    #1;
    check_y("comb_dis", Y_c, 4'b0000);
    E_c = 1'b1;
    #1;
    check_y("comb_en", Y_c, 4'b1000);
    rst_n_c = 1'b0;
    #1;
    check_y("comb_reset", Y_c, 4'b0000);
    rst_n_c = 1'b1;
    #1;
    check_y("comb_release", Y_c, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
